// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks a NUM_IN-input combinational block through every
// input row, samples its NUM_OUT outputs after a settle delay, streams each row
// to a logger over valid/ready and builds one minterm mask per function.
module truth_table_sequencer #(
  parameter int NUM_IN        = 4,
  parameter int NUM_OUT       = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic [NUM_IN-1:0]               tt_in,
  input  logic [NUM_OUT-1:0]              tt_out,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [NUM_IN-1:0]               row_index,
  output logic [NUM_OUT-1:0]              row_data,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted,
  output logic [NUM_OUT*(2**NUM_IN)-1:0]  mask
);

  localparam int ROWS = 2 ** NUM_IN;
  // Settle counter is sized for the full legal SETTLE_CYCLES range (1..15).
  localparam int SW = 4;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_EMIT,
    S_FINISH
  } state_t;

  state_t               r_state,     w_state_next;
  // One extra bit so the terminal count ROWS is representable; its carry ends the sweep.
  logic [NUM_IN:0]      r_cnt,       w_cnt_next;
  logic [NUM_IN:0]      w_cnt_inc;
  logic [SW-1:0]        r_settle,    w_settle_next;
  logic [NUM_IN-1:0]    r_tt_in,     w_tt_in_next;
  logic                 r_row_valid, w_row_valid_next;
  logic [NUM_IN-1:0]    r_row_index, w_row_index_next;
  logic [NUM_OUT-1:0]   r_row_data,  w_row_data_next;
  logic                 r_done,      w_done_next;
  logic                 r_aborted,   w_aborted_next;
  logic                 w_mask_clr;
  logic                 w_mask_wr;

  assign w_cnt_inc = r_cnt + (NUM_IN + 1)'(1);

  // Next-state and next-register values; abort in any active state overrides everything.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_settle_next    = r_settle;
    w_tt_in_next     = r_tt_in;
    w_row_valid_next = r_row_valid;
    w_row_index_next = r_row_index;
    w_row_data_next  = r_row_data;
    w_done_next      = 1'b0;
    w_aborted_next   = 1'b0;
    w_mask_clr       = 1'b0;
    w_mask_wr        = 1'b0;

    if (abort && (r_state != S_IDLE)) begin
      w_state_next     = S_IDLE;
      w_row_valid_next = 1'b0;
      w_tt_in_next     = '0;
      w_aborted_next   = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_mask_clr    = 1'b1;
            w_cnt_next    = '0;
            w_tt_in_next  = '0;
            w_settle_next = SETTLE_LOAD;
            w_state_next  = S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Leaving on the cycle the count would hit zero gives exactly SETTLE_CYCLES cycles here.
          w_settle_next = r_settle - SW'(1);
          if (r_settle <= SW'(1)) begin
            w_state_next = S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          w_mask_wr        = 1'b1;
          w_row_data_next  = tt_out;
          w_row_index_next = r_cnt[NUM_IN-1:0];
          w_row_valid_next = 1'b1;
          w_state_next     = S_EMIT;
        end
        S_EMIT: begin
          if (row_ready) begin
            w_cnt_next       = w_cnt_inc;
            w_row_valid_next = 1'b0;
            if (w_cnt_inc[NUM_IN]) begin
              w_state_next = S_FINISH;
            end else begin
              w_tt_in_next  = w_cnt_inc[NUM_IN-1:0];
              w_settle_next = SETTLE_LOAD;
              w_state_next  = S_SETTLE;
            end
          end
        end
        S_FINISH: begin
          w_done_next  = 1'b1;
          w_tt_in_next = '0;
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_settle    <= '0;
      r_tt_in     <= '0;
      r_row_valid <= 1'b0;
      r_row_index <= '0;
      r_row_data  <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_settle    <= w_settle_next;
      r_tt_in     <= w_tt_in_next;
      r_row_valid <= w_row_valid_next;
      r_row_index <= w_row_index_next;
      r_row_data  <= w_row_data_next;
      r_done      <= w_done_next;
      r_aborted   <= w_aborted_next;
    end
  end

  // One minterm field per function; each field captures its output bit at the sampled row.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_func
    logic [ROWS-1:0] r_field;

    // Clear on an accepted start, set the current row's bit during SAMPLE, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_field <= '0;
      end else if (w_mask_clr) begin
        r_field <= '0;
      end else if (w_mask_wr) begin
        r_field[r_cnt[NUM_IN-1:0]] <= tt_out[gi];
      end
    end

    assign mask[gi*ROWS +: ROWS] = r_field;
  end

  assign tt_in     = r_tt_in;
  assign row_valid = r_row_valid;
  assign row_index = r_row_index;
  assign row_data  = r_row_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with a reference datapath:
// f1 = x+y'z, f2 = w^z, f3 = wxyz+w'x'y'z', f4 = y, f5 = 0, f6 = 1.
module tb_truth_table_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  tt_in;
  logic [5:0]  tt_out;
  logic        row_valid;
  logic        row_ready;
  logic [3:0]  row_index;
  logic [5:0]  row_data;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [95:0] mask;

  // Hand-computed masks {f6,f5,f4,f3,f2,f1}
  localparam logic [95:0] FULL_MASK = 96'hFFFF_0000_CCCC_8001_55AA_F2F2;
  // Rows 0..8 only
  localparam logic [95:0] ROW8_MASK = 96'h01FF_0000_00CC_0001_01AA_00F2;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state (written only by the monitor process)
  logic [3:0] idx_log [0:63];
  logic [5:0] data_log[0:63];
  int log_n    = 0;
  int done_cnt = 0;
  int term_cnt = 0;
  logic prev16 = 1'b0;

  truth_table_sequencer #(
    .NUM_IN(4),
    .NUM_OUT(6),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .tt_in(tt_in),
    .tt_out(tt_out),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_index(row_index),
    .row_data(row_data),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .mask(mask)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] model(input logic [3:0] r);
    logic w, x, y, z;
    w = r[3]; x = r[2]; y = r[1]; z = r[0];
    return {1'b1, 1'b0, y, (w & x & y & z) | (~w & ~x & ~y & ~z), w ^ z, x | (~y & z)};
  endfunction

  assign tt_out = model(tt_in);

  // Log handshakes, done pulses and entries of the row counter into its terminal value.
  always @(negedge clk) begin
    if (row_valid && row_ready && log_n < 64) begin
      idx_log[log_n]  = row_index;
      data_log[log_n] = row_data;
      log_n++;
    end
    if (done) done_cnt++;
    if (dut.r_cnt == 5'd16 && !prev16) term_cnt++;
    prev16 = (dut.r_cnt == 5'd16);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; row_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (tt_in !== 4'd0)     begin n_bad++; $display("FAIL reset_tt_in got=%h exp=0", tt_in); end
    n_cmp++; if (row_valid !== 1'b0) begin n_bad++; $display("FAIL reset_row_valid got=%b exp=0", row_valid); end
    n_cmp++; if (row_index !== 4'd0) begin n_bad++; $display("FAIL reset_row_index got=%h exp=0", row_index); end
    n_cmp++; if (row_data !== 6'd0)  begin n_bad++; $display("FAIL reset_row_data got=%h exp=0", row_data); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (aborted !== 1'b0)   begin n_bad++; $display("FAIL reset_aborted got=%b exp=0", aborted); end
    n_cmp++; if (mask !== 96'd0)     begin n_bad++; $display("FAIL reset_mask got=%h exp=0", mask); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_full_sweep();
    int n;
    int base_log, base_term, base_done;
    base_log = log_n; base_term = term_cnt; base_done = done_cnt;
    start = 1'b1; row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 0;
    while (done !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL sweep_latency got=%0d exp=65", n); end
    n_cmp++; if (mask[15:0] !== 16'hF2F2)  begin n_bad++; $display("FAIL sweep_mask_f1 got=%h exp=f2f2", mask[15:0]); end
    n_cmp++; if (mask[47:32] !== 16'h8001) begin n_bad++; $display("FAIL sweep_mask_f3 got=%h exp=8001", mask[47:32]); end
    n_cmp++; if (mask !== FULL_MASK)       begin n_bad++; $display("FAIL sweep_mask_all got=%h exp=%h", mask, FULL_MASK); end
    n_cmp++; if (busy !== 1'b0)            begin n_bad++; $display("FAIL sweep_busy_at_done got=%b exp=0", busy); end
    n_cmp++; if (tt_in !== 4'd0)           begin n_bad++; $display("FAIL sweep_tt_in_at_done got=%h exp=0", tt_in); end
    n_cmp++; if (log_n - base_log !== 16)  begin n_bad++; $display("FAIL sweep_row_count got=%0d exp=16", log_n - base_log); end
    for (int i = 0; i < 16 && base_log + i < log_n; i++) begin
      n_cmp++;
      if (idx_log[base_log+i] !== 4'(i)) begin
        n_bad++; $display("FAIL sweep_row_index[%0d] got=%h exp=%h", i, idx_log[base_log+i], 4'(i));
      end
      n_cmp++;
      if (data_log[base_log+i] !== model(4'(i))) begin
        n_bad++; $display("FAIL sweep_row_data[%0d] got=%h exp=%h", i, data_log[base_log+i], model(4'(i)));
      end
    end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL sweep_done_pulse_width got=%b exp=0", done); end
    n_cmp++; if (term_cnt - base_term !== 1) begin n_bad++; $display("FAIL sweep_counter_terminal got=%0d exp=1", term_cnt - base_term); end
    n_cmp++; if (done_cnt - base_done !== 1) begin n_bad++; $display("FAIL sweep_done_count got=%0d exp=1", done_cnt - base_done); end
    $display("test_full_sweep done: %0d cycles", n);
  endtask

  task automatic test_backpressure();
    int n;
    int base_log;
    bit stalled;
    base_log = log_n; stalled = 1'b0;
    start = 1'b1; row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 0;
    while (done !== 1'b1 && n < 300) begin
      if (!stalled && row_valid === 1'b1 && row_index === 4'd3) begin
        row_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1; n++;
          n_cmp++; if (row_valid !== 1'b1)       begin n_bad++; $display("FAIL bp_row_valid[%0d] got=%b exp=1", k, row_valid); end
          n_cmp++; if (row_index !== 4'd3)       begin n_bad++; $display("FAIL bp_row_index[%0d] got=%h exp=3", k, row_index); end
          n_cmp++; if (row_data !== model(4'd3)) begin n_bad++; $display("FAIL bp_row_data[%0d] got=%h exp=%h", k, row_data, model(4'd3)); end
          n_cmp++; if (tt_in !== 4'd3)           begin n_bad++; $display("FAIL bp_tt_in[%0d] got=%h exp=3", k, tt_in); end
        end
        row_ready = 1'b1;
        stalled = 1'b1;
      end else begin
        @(posedge clk); #1; n++;
      end
    end
    n_cmp++; if (stalled !== 1'b1)        begin n_bad++; $display("FAIL bp_row3_seen got=%b exp=1", stalled); end
    n_cmp++; if (n !== 70)                begin n_bad++; $display("FAIL bp_latency got=%0d exp=70", n); end
    n_cmp++; if (mask !== FULL_MASK)      begin n_bad++; $display("FAIL bp_mask got=%h exp=%h", mask, FULL_MASK); end
    n_cmp++; if (log_n - base_log !== 16) begin n_bad++; $display("FAIL bp_row_count got=%0d exp=16", log_n - base_log); end
    $display("test_backpressure done: %0d cycles", n);
  endtask

  task automatic test_start_while_busy();
    int n;
    int hold;
    bit pulsed;
    pulsed = 1'b0; hold = 0;
    start = 1'b1; row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 0;
    while (done !== 1'b1 && n < 300) begin
      if (!pulsed && busy === 1'b1 && tt_in === 4'd4) begin
        start = 1'b1; pulsed = 1'b1; hold = 3;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) start = 1'b0;
      end
      @(posedge clk); #1; n++;
    end
    start = 1'b0;
    n_cmp++; if (n !== 65)           begin n_bad++; $display("FAIL swb_latency got=%0d exp=65", n); end
    n_cmp++; if (mask !== FULL_MASK) begin n_bad++; $display("FAIL swb_mask got=%h exp=%h", mask, FULL_MASK); end
    // start in the IDLE cycle that shows done: new sweep begins and mask clears at once
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1)  begin n_bad++; $display("FAIL restart_busy got=%b exp=1", busy); end
    n_cmp++; if (mask !== 96'd0) begin n_bad++; $display("FAIL restart_mask_clear got=%h exp=0", mask); end
    n_cmp++; if (tt_in !== 4'd0) begin n_bad++; $display("FAIL restart_tt_in got=%h exp=0", tt_in); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++; if (aborted !== 1'b1) begin n_bad++; $display("FAIL restart_abort got=%b exp=1", aborted); end
    @(posedge clk); #1;
    $display("test_start_while_busy done: %0d cycles", n);
  endtask

  task automatic test_abort();
    int n;
    int base_log, base_done;
    base_log = log_n; base_done = done_cnt;
    start = 1'b1; row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 0;
    while (!(busy === 1'b1 && tt_in === 4'd9) && n < 300) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n !== 36)           begin n_bad++; $display("FAIL abort_row9_reach got=%0d exp=36", n); end
    n_cmp++; if (row_valid !== 1'b0) begin n_bad++; $display("FAIL abort_in_settle_valid got=%b exp=0", row_valid); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++; if (aborted !== 1'b1)   begin n_bad++; $display("FAIL abort_pulse got=%b exp=1", aborted); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (tt_in !== 4'd0)     begin n_bad++; $display("FAIL abort_tt_in got=%h exp=0", tt_in); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL abort_done got=%b exp=0", done); end
    n_cmp++; if (mask !== ROW8_MASK) begin n_bad++; $display("FAIL abort_mask got=%h exp=%h", mask, ROW8_MASK); end
    @(posedge clk); #1;
    n_cmp++; if (aborted !== 1'b0)         begin n_bad++; $display("FAIL abort_pulse_width got=%b exp=0", aborted); end
    n_cmp++; if (done_cnt - base_done !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - base_done); end
    n_cmp++; if (log_n - base_log !== 9)   begin n_bad++; $display("FAIL abort_row_count got=%0d exp=9", log_n - base_log); end
    // abort while idle does nothing
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++; if (aborted !== 1'b0)   begin n_bad++; $display("FAIL abort_idle_pulse got=%b exp=0", aborted); end
    n_cmp++; if (mask !== ROW8_MASK) begin n_bad++; $display("FAIL abort_idle_mask got=%h exp=%h", mask, ROW8_MASK); end
    $display("test_abort done");
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    int base_done;
    base_done = done_cnt;
    start = 1'b1; row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 0;
    while (!(busy === 1'b1 && tt_in === 4'd7) && n < 300) begin @(posedge clk); #1; n++; end
    n_cmp++; if (tt_in !== 4'd7) begin n_bad++; $display("FAIL rst_mid_reach_row7 got=%h exp=7", tt_in); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_cmp++; if (tt_in !== 4'd0)     begin n_bad++; $display("FAIL rst_mid_tt_in got=%h exp=0", tt_in); end
    n_cmp++; if (row_index !== 4'd0) begin n_bad++; $display("FAIL rst_mid_row_index got=%h exp=0", row_index); end
    n_cmp++; if (row_data !== 6'd0)  begin n_bad++; $display("FAIL rst_mid_row_data got=%h exp=0", row_data); end
    n_cmp++; if (mask !== 96'd0)     begin n_bad++; $display("FAIL rst_mid_mask got=%h exp=0", mask); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst_mid_idle_busy got=%b exp=0", busy); end
      n_cmp++; if (aborted !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_aborted got=%b exp=0", aborted); end
    end
    n_cmp++; if (done_cnt - base_done !== 0) begin n_bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cnt - base_done); end
    $display("test_reset_mid_sweep done");
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Clocked controller that drives a 4-input, 6-output combinational logic block through all 16 input rows, from row 0 to row 15.
- For each row it waits a settle time, samples the six function outputs, and streams each row to a logger over a valid/ready handshake.
- At the end of the sweep it presents one 16-bit minterm mask per function.
- It replaces hand-written loop-and-delay sweeps in benches and in on-board self-test.

Parameters:
- NUM_IN, 4: number of datapath inputs. Rows per sweep = 2**NUM_IN.
- NUM_OUT, 6: number of datapath function outputs.
- SETTLE_CYCLES, 2: clock cycles between driving a row and sampling it. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  cancel the sweep in progress.
- tt_in  out  NUM_IN  drive to the datapath; bit NUM_IN-1 = w (MSB), bit 0 = z (LSB).
- tt_out  in  NUM_OUT  datapath results; bit 0 = f1 ... bit 5 = f6.
- row_valid  out  1  a row record is presented.
- row_ready  in  1  logger accepts the record.
- row_index  out  NUM_IN  index of the presented row.
- row_data  out  NUM_OUT  sampled tt_out for that row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion of a full sweep.
- aborted  out  1  one-cycle pulse on cancellation.
- mask  out  NUM_OUT*2**NUM_IN  minterm masks; function k occupies bits [16k+15:16k], and bit r of that field = function k at row r.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE. All outputs are 0: tt_in, row_valid, row_index, row_data, busy, done, aborted, mask.
- Row counter is NUM_IN+1 bits wide so that the terminal count 2**NUM_IN is representable. Loop termination uses the carry bit; a 4-bit compare against 16 is not used.
- States:
  - IDLE: on start=1, clear mask, set counter=0, set tt_in=0, set settle count=SETTLE_CYCLES, go to SETTLE.
  - SETTLE: decrement the settle count each cycle. When it reaches 0, go to SAMPLE. tt_in holds counter[NUM_IN-1:0].
  - SAMPLE: register tt_out into row_data and into mask bit [counter] of each function field, set row_index=counter, set row_valid=1, go to EMIT.
  - EMIT: hold row_valid, row_index and row_data stable until row_ready=1. On the handshake cycle:
    - Increment the counter and deassert row_valid next cycle.
    - If the new counter equals 2**NUM_IN, go to FINISH.
    - Otherwise drive the new tt_in, reload the settle count, and go to SETTLE.
  - FINISH: pulse done for 1 cycle, set tt_in=0, go to IDLE.
- Row latency with row_ready held high: exactly SETTLE_CYCLES+2 cycles per row. Full sweep = 16*(SETTLE_CYCLES+2)+1 cycles from the start edge to the done pulse.
- start while busy is ignored. start held high in IDLE after done launches a new sweep the next cycle.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, row_valid=0, tt_in=0, aborted pulses.
  - done is not asserted.
  - mask keeps its partial contents; rows not yet sampled read 0.
- abort and row_ready in the same cycle: abort wins and the row is not counted.
- abort in IDLE has no effect.
- Asynchronous reset mid-sweep: immediate return to the reset values; no done or aborted pulse.
- mask is stable from FINISH until the next accepted start.
- row_data/mask sample tt_out exactly once per row, at the SAMPLE cycle. Later changes on tt_out are ignored.

Test Plan:
- Reset mid-sweep: assert rst_n=0 during row 7 -> all outputs go to 0 asynchronously, before the next clk edge. After release, the block sits in IDLE with busy=0.
- Full sweep with f1 = x+y'z and f3 = wxyz+w'x'y'z' from a reference datapath model, row_ready tied 1, SETTLE_CYCLES=2:
  - done arrives 65 cycles after the start edge.
  - mask[15:0] = 0xF2F2.
  - mask[47:32] = 0x8001.
  - row_index sequence 0..15, each index once.
- Backpressure: row_ready low for 5 cycles at row 3 -> row_valid, row_index=3 and row_data are held stable. tt_in stays 3 and does not advance. Total sweep length grows by 5.
- Counter terminal: monitor the internal counter and tt_in -> tt_in never exceeds 15, the counter reaches 16 exactly once, and the sweep terminates. There is no infinite loop.
- Abort at row 9 during SETTLE -> aborted pulses, done stays 0, tt_in=0. mask bits for rows 0..8 match the model and bits 9..15 are 0.
- start asserted during busy at row 4 -> no restart, and the sweep completes normally. A new start after done clears mask in the first cycle.
